mclaurin_pipeline_param: RTL

Parametrised successor to the fixed 8-bit Maclaurin pipeline. Evaluates y = sum_{k=0..N} c_k * x^k in signed fixed point using a fully pipelined Horner chain of TERMS stages. Precision N is selected per sample, and the coefficient set is a parameter (default exp(x)). Adds valid/ready handshaking with backpressure, saturating arithmetic and a per-sample sticky overflow flag; it sits between the sample source and the result consumer in the series-evaluation datapath.

---
 rtl/mclaurin_pipeline_param.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mclaurin_pipeline_param.sv
// Fully pipelined Horner evaluator of a fixed-point Maclaurin series with per-sample precision,
// valid/ready backpressure, saturating arithmetic and a sticky per-sample overflow flag.
module mclaurin_pipeline_param #(
  parameter int X_W      = 8,
  parameter int X_FRAC   = 6,
  parameter int ACC_W    = 32,
  parameter int ACC_FRAC = 24,
  parameter int TERMS    = 8,
  parameter int N_W      = 3,
  parameter logic [TERMS*ACC_W-1:0] COEFFS = {
    32'h00000D01, 32'h00005B06, 32'h00022222, 32'h000AAAAB,
    32'h002AAAAB, 32'h00800000, 32'h01000000, 32'h01000000
  }
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [X_W-1:0]   x,
  input  logic [N_W-1:0]   N,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] y,
  output logic             overflow
);

  localparam int PW = ACC_W + X_W;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  if (N_W != $clog2(TERMS) || ACC_FRAC >= ACC_W || X_FRAC >= X_W) begin : g_bad_params
    $error("mclaurin_pipeline_param: inconsistent width parameters");
  end

  // Register 0 is the input register; register s+1 holds the result of the stage using c_(TERMS-1-s).
  logic                    vld     [0:TERMS];
  logic signed [ACC_W-1:0] acc     [0:TERMS];
  logic                    ovf     [0:TERMS];
  logic signed [X_W-1:0]   xs      [0:TERMS-1];
  logic [N_W-1:0]          ns      [0:TERMS-1];
  logic signed [ACC_W-1:0] acc_nxt [0:TERMS-1];
  logic                    ovf_nxt [0:TERMS-1];

  logic           stall;
  logic           adv;
  logic [N_W-1:0] n_in;

  assign stall     = vld[TERMS] & ~out_ready;
  assign adv       = ~stall;
  assign in_ready  = ~stall;
  assign out_valid = vld[TERMS];
  assign y         = acc[TERMS];
  assign overflow  = ovf[TERMS];

  // Only reachable when TERMS is not a power of two.
  assign n_in = (int'(N) > TERMS - 1) ? N_W'(TERMS - 1) : N;

  for (genvar s = 0; s < TERMS; s++) begin : g_stage
    localparam int K = TERMS - 1 - s;
    localparam logic [N_W-1:0] KN = N_W'(K);
    localparam logic signed [ACC_W-1:0] CK = COEFFS[K*ACC_W +: ACC_W];

    logic signed [PW-1:0]    prod;
    logic signed [PW-1:0]    prod_sh;
    logic [X_W:0]            hi;
    logic signed [ACC_W-1:0] mid;
    logic signed [ACC_W-1:0] coef;
    logic signed [ACC_W:0]   sum;
    logic                    clamp_mul;
    logic                    clamp_add;

    // Both operands are sign-extended to the full product width so the truncated product is exact.
    always_comb begin
      prod      = $signed({{X_W{acc[s][ACC_W-1]}}, acc[s]}) *
                  $signed({{ACC_W{xs[s][X_W-1]}}, xs[s]});
      prod_sh   = prod >>> X_FRAC;
      hi        = prod_sh[PW-1:ACC_W-1];
      clamp_mul = !((&hi) || !(|hi));
      if (clamp_mul) begin
        mid = prod_sh[PW-1] ? ACC_MIN : ACC_MAX;
      end else begin
        mid = prod_sh[ACC_W-1:0];
      end
      coef      = (KN <= ns[s]) ? CK : '0;
      sum       = {mid[ACC_W-1], mid} + {coef[ACC_W-1], coef};
      clamp_add = sum[ACC_W] != sum[ACC_W-1];
      if (clamp_add) begin
        acc_nxt[s] = sum[ACC_W] ? ACC_MIN : ACC_MAX;
      end else begin
        acc_nxt[s] = sum[ACC_W-1:0];
      end
      ovf_nxt[s] = ovf[s] | clamp_mul | clamp_add;
    end
  end

  // The whole pipe, output register included, moves together; bubbles advance like samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s <= TERMS; s++) begin
        vld[s] <= 1'b0;
        acc[s] <= '0;
        ovf[s] <= 1'b0;
      end
      for (int s = 0; s < TERMS; s++) begin
        xs[s] <= '0;
        ns[s] <= '0;
      end
    end else if (adv) begin
      vld[0] <= in_valid;
      acc[0] <= '0;
      ovf[0] <= 1'b0;
      xs[0]  <= x;
      ns[0]  <= n_in;
      for (int s = 0; s < TERMS; s++) begin
        vld[s+1] <= vld[s];
        acc[s+1] <= acc_nxt[s];
        ovf[s+1] <= ovf_nxt[s];
      end
      for (int s = 1; s < TERMS; s++) begin
        xs[s] <= xs[s-1];
        ns[s] <= ns[s-1];
      end
    end
  end

endmodule
